// File: rtl/enemy_render.sv
// enemy_render: per-frame erase/draw of up to NPLANE 4x4 enemy sprites,
// streamed one pixel per cycle to the VGA adapter.
// NEW bank holds the positions to draw; OLD bank holds what is on screen.
module enemy_render #(
  parameter int SPR    = 4,
  parameter int NPLANE = 10,
  parameter int XMAX   = 159,
  parameter int YMAX   = 119
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_coord,
  input  logic                  datapath_en,
  input  logic [1:0]            op,
  input  logic [8*NPLANE-1:0]   x_all,
  input  logic [8*NPLANE-1:0]   y_all,
  input  logic [3*NPLANE-1:0]   vis_all,
  output logic [7:0]            x_out,
  output logic [6:0]            y_out,
  output logic [2:0]            colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  done
);

  // Last pixel index within a slot and last slot index.
  localparam logic [3:0] PIX_LAST  = 4'(SPR * SPR - 1);
  localparam logic [3:0] SLOT_LAST = 4'(NPLANE - 1);
  // Clip limits widened to the 9-bit sum width so carries are never lost.
  localparam logic [8:0] XLIM = 9'(XMAX);
  localparam logic [8:0] YLIM = 9'(YMAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ERASE  = 2'd1,
    S_DRAW   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0] op_lat;
  logic [3:0] slot;
  logic [3:0] pix;

  logic [7:0] new_x   [NPLANE];
  logic [7:0] new_y   [NPLANE];
  logic [2:0] new_vis [NPLANE];
  logic [7:0] old_x   [NPLANE];
  logic [7:0] old_y   [NPLANE];
  logic [2:0] old_vis [NPLANE];

  logic       active;
  logic       slot_end;
  logic       phase_end;
  logic [7:0] src_x;
  logic [7:0] src_y;
  logic [2:0] src_vis;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic       pix_on;

  assign active    = (state == S_ERASE) || (state == S_DRAW);
  assign slot_end  = (pix == PIX_LAST);
  assign phase_end = slot_end && (slot == SLOT_LAST);

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: erase pass (OLD bank) precedes draw pass (NEW bank).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (datapath_en) begin
          if (op[0]) begin
            next_state = S_ERASE;
          end else if (op[1]) begin
            next_state = S_DRAW;
          end else begin
            next_state = S_FINISH;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_ERASE: begin
        if (phase_end) begin
          next_state = op_lat[1] ? S_DRAW : S_FINISH;
        end else begin
          next_state = S_ERASE;
        end
      end
      S_DRAW: begin
        if (phase_end) begin
          next_state = S_FINISH;
        end else begin
          next_state = S_DRAW;
        end
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Capture the frame type when a frame is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_lat <= 2'b00;
    end else if ((state == S_IDLE) && datapath_en) begin
      op_lat <= op;
    end else begin
      op_lat <= op_lat;
    end
  end

  // Slot/pixel walk: fixed 16 cycles per slot, restarting at each pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix  <= 4'd0;
      slot <= 4'd0;
    end else if (active) begin
      pix <= slot_end ? 4'd0 : pix + 4'd1;
      if (phase_end) begin
        slot <= 4'd0;
      end else if (slot_end) begin
        slot <= slot + 4'd1;
      end else begin
        slot <= slot;
      end
    end else begin
      pix  <= 4'd0;
      slot <= 4'd0;
    end
  end

  // Coordinate banks: NEW loads only while idle, OLD follows at frame end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPLANE; i++) begin
        new_x[i]   <= 8'd0;
        new_y[i]   <= 8'd0;
        new_vis[i] <= 3'd0;
        old_x[i]   <= 8'd0;
        old_y[i]   <= 8'd0;
        old_vis[i] <= 3'd0;
      end
    end else begin
      if ((state == S_IDLE) && load_coord) begin
        for (int i = 0; i < NPLANE; i++) begin
          new_x[i]   <= x_all[8*i +: 8];
          new_y[i]   <= y_all[8*i +: 8];
          new_vis[i] <= vis_all[3*i +: 3];
        end
      end
      if (state == S_FINISH) begin
        if (op_lat[1]) begin
          // Whatever was just drawn is now what is on screen.
          for (int i = 0; i < NPLANE; i++) begin
            old_x[i]   <= new_x[i];
            old_y[i]   <= new_y[i];
            old_vis[i] <= new_vis[i];
          end
        end else if (op_lat[0]) begin
          // Erase-only frame leaves nothing on screen.
          for (int i = 0; i < NPLANE; i++) begin
            old_vis[i] <= 3'd0;
          end
        end
      end
    end
  end

  // Select the bank entry for the current slot and form the clipped pixel.
  always_comb begin
    src_x   = 8'd0;
    src_y   = 8'd0;
    src_vis = 3'd0;
    if (state == S_ERASE) begin
      src_x   = old_x[slot];
      src_y   = old_y[slot];
      src_vis = old_vis[slot];
    end else begin
      src_x   = new_x[slot];
      src_y   = new_y[slot];
      src_vis = new_vis[slot];
    end
    sum_x  = {1'b0, src_x} + {7'd0, pix[1:0]};
    sum_y  = {1'b0, src_y} + {7'd0, pix[3:2]};
    pix_on = active && (src_vis != 3'd0) && (sum_x <= XLIM) && (sum_y <= YLIM);
  end

  // Registered pixel stream and frame status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out  <= 8'd0;
      y_out  <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      x_out  <= active ? sum_x[7:0] : 8'd0;
      y_out  <= active ? sum_y[6:0] : 7'd0;
      colour <= (state == S_DRAW) ? src_vis : 3'd0;
      plot   <= pix_on;
      busy   <= (state != S_IDLE);
      done   <= (state == S_FINISH);
    end
  end

endmodule

// File: tb/tb_enemy_render.sv
// Bench for enemy_render: a scripted table of frames, hand-written
// mid-frame disturbance and reset sequences, then random frames, all
// checked cycle by cycle against a bank/raster reference model.
module tb_enemy_render;

  localparam int NP = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_coord;
  logic        datapath_en;
  logic [1:0]  op;
  logic [79:0] x_all;
  logic [79:0] y_all;
  logic [29:0] vis_all;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Reference model banks and staging values for the next load.
  int m_new_x [NP];
  int m_new_y [NP];
  int m_new_v [NP];
  int m_old_x [NP];
  int m_old_y [NP];
  int m_old_v [NP];
  int s_x [NP];
  int s_y [NP];
  int s_v [NP];

  typedef struct {
    int         plane;
    int         x;
    int         y;
    int         v;
    logic [1:0] fop;
    int         exp_plots;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  enemy_render dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_coord  (load_coord),
    .datapath_en (datapath_en),
    .op          (op),
    .x_all       (x_all),
    .y_all       (y_all),
    .vis_all     (vis_all),
    .x_out       (x_out),
    .y_out       (y_out),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      m_new_x[i] = 0; m_new_y[i] = 0; m_new_v[i] = 0;
      m_old_x[i] = 0; m_old_y[i] = 0; m_old_v[i] = 0;
    end
  endtask

  task automatic set_only(input int plane, input int x, input int y, input int v);
    for (int i = 0; i < NP; i++) begin
      s_x[i] = 0; s_y[i] = 0; s_v[i] = 0;
    end
    s_x[plane] = x; s_y[plane] = y; s_v[plane] = v;
  endtask

  task automatic drive_staging();
    for (int i = 0; i < NP; i++) begin
      x_all[8*i +: 8]   = 8'(s_x[i]);
      y_all[8*i +: 8]   = 8'(s_y[i]);
      vis_all[3*i +: 3] = 3'(s_v[i]);
    end
  endtask

  // Called at a negedge while the DUT is idle; model NEW follows the load.
  task automatic do_load();
    drive_staging();
    load_coord = 1'b1;
    @(negedge clk);
    load_coord = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_new_x[i] = s_x[i]; m_new_y[i] = s_y[i]; m_new_v[i] = s_v[i];
    end
  endtask

  // Start a frame and check every cycle T+1 .. T+len+2 against the model.
  // disturb_at: cycle at which garbage load/start strobes are injected.
  // abort_at: cycle at which reset is asserted (frame abandoned).
  task automatic run_frame(input logic [1:0] fop, input int disturb_at, input int abort_at,
                           output int nplots, output int first_plot, output int last_plot);
    int len, idx, slot, pp, bx, by, bv, sx, sy, ec;
    logic er, ep;
    nplots = 0; first_plot = -1; last_plot = -1;
    len = (fop[0] ? 160 : 0) + (fop[1] ? 160 : 0);
    op = fop;
    datapath_en = 1'b1;
    @(negedge clk);
    datapath_en = 1'b0;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      load_coord  = 1'b0;
      datapath_en = 1'b0;
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("reset_async_outputs", {11'd0, x_out, y_out, colour, plot, busy, done}, 32'd0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("reset_hold", {29'd0, plot, busy, done}, 32'd0);
        end
        reset_n = 1'b1;
        clear_model();
        return;
      end
      if (plot === 1'b1) begin
        nplots++;
        if (first_plot < 0) first_plot = k;
        last_plot = k;
      end
      if (k <= len) begin
        idx = k - 1;
        er  = fop[0] && (idx < 160);
        if (!er && fop[0]) idx = idx - 160;
        slot = idx / 16;
        pp   = idx % 16;
        bx = er ? m_old_x[slot] : m_new_x[slot];
        by = er ? m_old_y[slot] : m_new_y[slot];
        bv = er ? m_old_v[slot] : m_new_v[slot];
        sx = bx + (pp % 4);
        sy = by + (pp / 4);
        ep = (bv != 0) && (sx <= 159) && (sy <= 119);
        ec = er ? 0 : bv;
        check(er ? "erase_pixel" : "draw_pixel",
              {11'd0, x_out, y_out, colour, plot, busy, done},
              {11'd0, 8'(sx), 7'(sy), 3'(ec), ep, 1'b1, 1'b0});
      end else if (k == len + 1) begin
        check("done_cycle", {29'd0, plot, busy, done}, {29'd0, 1'b0, 1'b1, 1'b1});
      end else begin
        check("after_done", {29'd0, plot, busy, done}, 32'd0);
      end
      if (k == disturb_at) begin
        for (int i = 0; i < NP; i++) begin
          s_x[i] = 0; s_y[i] = 0; s_v[i] = 7;
        end
        drive_staging();
        load_coord  = 1'b1;
        datapath_en = 1'b1;
        op          = 2'b11;
      end
    end
    if (fop[1]) begin
      for (int i = 0; i < NP; i++) begin
        m_old_x[i] = m_new_x[i]; m_old_y[i] = m_new_y[i]; m_old_v[i] = m_new_v[i];
      end
    end else if (fop[0]) begin
      for (int i = 0; i < NP; i++) m_old_v[i] = 0;
    end
  endtask

  initial begin
    int np, fp, lp;
    logic [1:0] rop;

    tbl[0] = '{0,  10,  20, 4, 2'b10, 16,  1,  16};
    tbl[1] = '{0,  11,  20, 4, 2'b11, 32,  1, 176};
    tbl[2] = '{3, 158, 118, 2, 2'b10,  4, 49,  54};
    tbl[3] = '{5, 254,  50, 7, 2'b11,  4, 49,  54};
    tbl[4] = '{2,  30,  40, 3, 2'b01,  0, -1,  -1};
    tbl[5] = '{9, 100, 116, 5, 2'b00,  0, -1,  -1};
    tbl[6] = '{9, 100, 116, 5, 2'b11, 16, 305, 320};

    reset_n = 1'b0; load_coord = 1'b0; datapath_en = 1'b0; op = 2'b00;
    x_all = 80'd0; y_all = 80'd0; vis_all = 30'd0;
    clear_model();
    repeat (3) @(negedge clk);
    check("reset_outputs", {11'd0, x_out, y_out, colour, plot, busy, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {11'd0, x_out, y_out, colour, plot, busy, done}, 32'd0);

    // Scripted frames: single plane per row, plus boundary and clipping rows.
    for (int r = 0; r < 7; r++) begin
      set_only(tbl[r].plane, tbl[r].x, tbl[r].y, tbl[r].v);
      do_load();
      run_frame(tbl[r].fop, 0, 0, np, fp, lp);
      check("tbl_plot_count", np, tbl[r].exp_plots);
      check("tbl_first_plot", fp, tbl[r].exp_first);
      check("tbl_last_plot",  lp, tbl[r].exp_last);
    end

    // Strobes mid-frame must not disturb this frame nor the next one.
    for (int i = 0; i < NP; i++) begin
      s_x[i] = 10 * i + 3; s_y[i] = 7 * i + 1; s_v[i] = (i % 7) + 1;
    end
    do_load();
    run_frame(2'b10, 50, 0, np, fp, lp);
    check("disturbed_frame_plots", np, 160);
    run_frame(2'b10, 0, 0, np, fp, lp);
    check("post_disturb_plots", np, 160);

    // Reset in the middle of an erase+draw frame, then an empty erase.
    run_frame(2'b11, 0, 100, np, fp, lp);
    run_frame(2'b01, 0, 0, np, fp, lp);
    check("erase_after_reset_plots", np, 0);

    // Random frames, coordinates biased towards the clipping edges.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NP; i++) begin
        s_x[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 255);
        s_y[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 130) : $urandom_range(0, 255);
        s_v[i] = $urandom_range(0, 7);
      end
      rop = 2'($urandom_range(0, 3));
      do_load();
      run_frame(rop, 0, 0, np, fp, lp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
